// File: rtl/dca_lsu_row_packer.sv
// Packs AXI read-data beats into fixed-length element rows and buffers completed
// rows in a small FIFO; short transactions are zero-padded and flagged.
module dca_lsu_row_packer #(
  parameter int BW_AXI_DATA      = 32,
  parameter int BW_ELEMENT       = 8,
  parameter int MAX_ROW_ELEMENTS = 16,
  parameter int ROW_FIFO_DEPTH   = 2,
  localparam int CFG_W = $clog2(MAX_ROW_ELEMENTS + 1),
  localparam int ROW_W = MAX_ROW_ELEMENTS * BW_ELEMENT
) (
  input  logic                   clk,
  input  logic                   rstnn,
  input  logic                   clear,
  input  logic [CFG_W-1:0]       cfg_num_elements,
  input  logic                   rdata_valid,
  output logic                   rdata_ready,
  input  logic [BW_AXI_DATA-1:0] rdata,
  input  logic                   rdata_last,
  output logic                   row_valid,
  input  logic                   row_ready,
  output logic [ROW_W-1:0]       row_data,
  output logic                   row_last,
  output logic                   busy,
  output logic                   pad_error,
  output logic [15:0]            row_count
);

  // state  | meaning
  // S_IDLE | no elements of the current row held
  // S_FILL | 1..L-1 elements held in the partial-row buffer

  localparam int EPB   = BW_AXI_DATA / BW_ELEMENT;
  localparam int PTR_W = (ROW_FIFO_DEPTH > 1) ? $clog2(ROW_FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(ROW_FIFO_DEPTH + 1);
  localparam logic [CFG_W-1:0] MAX_LEN  = CFG_W'(MAX_ROW_ELEMENTS);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(ROW_FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(ROW_FIFO_DEPTH - 1);

  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t                  state_q, state_d;
  logic [CFG_W-1:0]        fill_q, fill_d, len_q, len_d, len_eff, len_cur;
  logic [ROW_W-1:0]        part_q, part_d, row_next;
  logic [ROW_W-1:0]        mem_q [ROW_FIFO_DEPTH];
  logic [ROW_W-1:0]        mem_d [ROW_FIFO_DEPTH];
  logic [ROW_FIFO_DEPTH-1:0] last_mem_q, last_mem_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    pad_error_q, pad_error_d;
  logic [15:0]             row_count_q, row_count_d;
  logic                    full, empty, complete, beat_fire, row_fire, push;

  assign full      = (cnt_q == DEPTH_C);
  assign empty     = (cnt_q == '0);
  assign beat_fire = rdata_valid & ~full & ~clear;
  assign row_fire  = row_ready & ~empty & ~clear;
  assign push      = beat_fire & (complete | rdata_last);

  // Row length is taken from cfg only on the first beat of a row.
  always_comb begin
    len_eff = cfg_num_elements;
    if ((cfg_num_elements == '0) || (cfg_num_elements > MAX_LEN)) len_eff = MAX_LEN;
    len_cur  = (state_q == S_IDLE) ? len_eff : len_q;
    complete = (int'(fill_q) + EPB) >= int'(len_cur);
    row_next = part_q;
    for (int p = 0; p < MAX_ROW_ELEMENTS; p++) begin
      for (int k = 0; k < EPB; k++) begin
        if ((p == int'(fill_q) + k) && (p < int'(len_cur)))
          row_next[p*BW_ELEMENT +: BW_ELEMENT] = rdata[k*BW_ELEMENT +: BW_ELEMENT];
      end
    end
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear)          state_d = S_IDLE;
    else if (beat_fire) state_d = push ? S_IDLE : S_FILL;
  end

  always_comb begin
    rdata_ready = ~full;
    row_valid   = ~empty;
    row_data    = empty ? '0 : mem_q[rd_ptr_q];
    row_last    = empty ? 1'b0 : last_mem_q[rd_ptr_q];
    busy        = (state_q == S_FILL) | ~empty;
    pad_error   = pad_error_q;
    row_count   = row_count_q;
  end

  always_comb begin
    fill_d      = fill_q;
    len_d       = len_q;
    part_d      = part_q;
    mem_d       = mem_q;
    last_mem_d  = last_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    pad_error_d = pad_error_q;
    row_count_d = row_count_q;
    if (clear) begin
      fill_d      = '0;
      len_d       = '0;
      part_d      = '0;
      last_mem_d  = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      cnt_d       = '0;
      pad_error_d = 1'b0;
      row_count_d = '0;
    end else begin
      if (beat_fire) begin
        if (push) begin
          fill_d               = '0;
          part_d               = '0;
          mem_d[wr_ptr_q]      = row_next;
          last_mem_d[wr_ptr_q] = rdata_last;
          wr_ptr_d             = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
          row_count_d          = row_count_q + 16'd1;
          if (!complete) pad_error_d = 1'b1;
        end else begin
          fill_d = fill_q + CFG_W'(EPB);
          part_d = row_next;
          len_d  = len_cur;
        end
      end
      if (row_fire) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(row_fire);
    end
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      fill_q      <= '0;
      len_q       <= '0;
      part_q      <= '0;
      for (int i = 0; i < ROW_FIFO_DEPTH; i++) mem_q[i] <= '0;
      last_mem_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      pad_error_q <= 1'b0;
      row_count_q <= '0;
    end else begin
      fill_q      <= fill_d;
      len_q       <= len_d;
      part_q      <= part_d;
      mem_q       <= mem_d;
      last_mem_q  <= last_mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      pad_error_q <= pad_error_d;
      row_count_q <= row_count_d;
    end
  end

endmodule
